// File: rtl/status_flag_if.sv
// Pipeline-side bundle for the status flag unit.
// The pipeline (master) drives the EX commit, explicit write and ID issue
// strobes; the flag unit (slave) returns the NZCV vector, hazard and counter.
// Strobe semantics: every strobe (ex_valid, wr_en, id_issue) is a single-cycle
// qualifier sampled on the rising clock edge. There is no backpressure path.
// stall gates all EX/ID updates. flush only clears the pending count.
interface status_flag_if #(
  parameter int PEND_W = 2
);
  logic              stall;
  logic              flush;
  logic              ex_valid;
  logic              ex_s_bit;
  logic              ex_cond_pass;
  logic [3:0]        alu_flags;
  logic              wr_en;
  logic [3:0]        wr_mask;
  logic [3:0]        wr_data;
  logic              id_issue;
  logic              id_flag_setter;
  logic              id_needs_flags;
  logic [3:0]        status_out;
  logic              flag_hazard;
  logic [PEND_W-1:0] pending_cnt;
  logic              cnt_err;

  modport master (
    output stall, flush, ex_valid, ex_s_bit, ex_cond_pass, alu_flags,
           wr_en, wr_mask, wr_data, id_issue, id_flag_setter, id_needs_flags,
    input  status_out, flag_hazard, pending_cnt, cnt_err
  );

  modport slave (
    input  stall, flush, ex_valid, ex_s_bit, ex_cond_pass, alu_flags,
           wr_en, wr_mask, wr_data, id_issue, id_flag_setter, id_needs_flags,
    output status_out, flag_hazard, pending_cnt, cnt_err
  );
endinterface

// File: rtl/status_flag_unit.sv
// NZCV status flag register with masked explicit writes and a counter of
// in-flight flag-setting instructions used to stall conditional decode.
// Optional macro STATUS_BYPASS_EN: forward the next-state flags to
// status_out combinationally and drop the hazard when the last pending
// setter retires in the current cycle.
module status_flag_unit #(
  parameter int         PEND_W      = 2,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic          clk,
  input  logic          rst_n,
  status_flag_if.slave  bus
);
  localparam logic [PEND_W-1:0] MAX_PEND = '1;
  localparam logic [PEND_W-1:0] ONE_PEND = PEND_W'(1);

  logic [3:0]        flags_q;
  logic [3:0]        flags_d;
  logic [PEND_W-1:0] cnt_q;
  logic              err_q;
  logic              retire;
  logic              commit;
  logic              inc;
  logic              dec;

  // An EX setter retires even when its condition fails; only commit writes flags.
  assign retire = bus.ex_valid & bus.ex_s_bit & ~bus.stall;
  assign commit = retire & bus.ex_cond_pass;
  assign inc    = bus.id_issue & bus.id_flag_setter & ~bus.stall & ~bus.flush;
  assign dec    = retire;

  // Next-state flags: ALU result first, then explicit write overrides masked bits.
  always_comb begin
    flags_d = flags_q;
    if (commit) begin
      flags_d = bus.alu_flags;
    end
    if (bus.wr_en && !bus.stall) begin
      flags_d = (flags_d & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);
    end
  end

  // Flag register; flags_d already equals flags_q while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= RESET_FLAGS;
    end else begin
      flags_q <= flags_d;
    end
  end

  // Pending setter counter with saturation and a sticky misuse flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (bus.flush) begin
      // Younger setters are gone; the retiring EX one no longer matters either.
      cnt_q <= '0;
    end else if (inc && !dec) begin
      if (cnt_q == MAX_PEND) begin
        err_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + ONE_PEND;
      end
    end else if (dec && !inc) begin
      if (cnt_q == '0) begin
        err_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q - ONE_PEND;
      end
    end
  end

  assign bus.pending_cnt = cnt_q;
  assign bus.cnt_err     = err_q;

`ifdef STATUS_BYPASS_EN
  assign bus.status_out  = flags_d;
  assign bus.flag_hazard = bus.id_needs_flags & (cnt_q != '0) &
                           ~((cnt_q == ONE_PEND) & retire);
`else
  assign bus.status_out  = flags_q;
  assign bus.flag_hazard = bus.id_needs_flags & (cnt_q != '0);
`endif
endmodule

// File: doc/status_flag_unit.md
Name: status_flag_unit

Overview:
- Holds the architectural NZCV status flags and feeds them to the condition-check stage as the 4-bit {N,Z,C,V} status vector.
- Commits ALU flag results from the EX stage when the instruction's S bit is set and its condition passed.
- Accepts masked explicit flag writes.
- Tracks in-flight flag-setting instructions so decode can stall a conditional instruction until its flags are settled.

Parameters:
- PEND_W, 2, width of the pending-setter counter; maximum count MAX_PEND = 2^PEND_W - 1.
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- stall  input  1  pipeline stall; freezes flags and counter.
- flush  input  1  kill younger instructions (ID and earlier).
- ex_valid  input  1  instruction valid in EX.
- ex_s_bit  input  1  EX instruction requests a flag update.
- ex_cond_pass  input  1  EX instruction's condition evaluated true.
- alu_flags  input  4  {N,Z,C,V} produced by the ALU.
- wr_en  input  1  explicit flag write strobe.
- wr_mask  input  4  per-bit enable for the explicit write, bit order {N,Z,C,V}.
- wr_data  input  4  explicit write data.
- id_issue  input  1  ID instruction issues to EX this cycle.
- id_flag_setter  input  1  issuing instruction has its S bit set.
- id_needs_flags  input  1  ID instruction's condition is not AL.
- status_out  output  4  {N,Z,C,V} to the condition-check stage.
- flag_hazard  output  1  decode must stall; flags not yet settled.
- pending_cnt  output  PEND_W  number of in-flight flag setters.
- cnt_err  output  1  sticky counter overflow/underflow error.

Behaviour:
- Reset: asynchronous on rst_n low.
  - flags <= RESET_FLAGS; pending_cnt <= 0; cnt_err <= 0; flag_hazard = 0.
  - Reset during operation discards all pending state immediately.
- Definitions: retire = ex_valid & ex_s_bit & ~stall; commit = retire & ex_cond_pass.
- Flag register update, rising edge, when ~stall:
  - commit: flags <= alu_flags.
  - wr_en: for each bit i with wr_mask[i]=1, flags[i] <= wr_data[i].
  - commit and wr_en in the same cycle: masked bits take wr_data; unmasked bits take alu_flags.
  - Neither: hold.
- stall=1: flags hold regardless of commit or wr_en.
- flush does not block the EX commit. The EX instruction is older than the flushed ones.
- Pending counter:
  - inc = id_issue & id_flag_setter & ~stall & ~flush; dec = retire (counts even when the condition fails).
  - inc & dec: unchanged. inc only: +1. dec only: -1.
  - flush=1: pending_cnt <= 0 and cnt_err is unchanged. flush overrides stall.
  - inc at MAX_PEND: saturate and set cnt_err.
  - dec at 0: stay 0 and set cnt_err.
  - cnt_err clears only on reset.
- flag_hazard (combinational) = id_needs_flags & (pending_cnt != 0).
- Latency: status_out = registered flags. A commit at edge k is visible to the condition check in the cycle following edge k (one-cycle latency).

Optional Feature:
- Macro: STATUS_BYPASS_EN.
- Defined:
  - status_out carries the next-state flag value combinationally, i.e. the result of the commit/wr_en merge above, or flags when stall=1.
  - flag_hazard additionally deasserts when pending_cnt==1 and retire=1 in the same cycle.
  - Consumers see the update with zero latency.
- Undefined: status_out is the registered flags only; flag_hazard is as defined in Behaviour.

Test Plan:
- Reset, then run 5 idle cycles -> status_out=RESET_FLAGS (4'b0000), pending_cnt=0, flag_hazard=0, cnt_err=0. Assert rst_n low mid-run with pending_cnt=2 -> pending_cnt=0 asynchronously.
- ex_valid=1, ex_s_bit=1, ex_cond_pass=1, alu_flags=4'b0110 -> status_out=4'b0110 next cycle. Same stimulus with ex_cond_pass=0 -> flags unchanged, pending_cnt still decrements.
- Same-cycle commit alu_flags=4'b1111 and wr_en=1, wr_mask=4'b1000, wr_data=4'b0000 -> status_out=4'b0111. Any commit with stall=1 -> no change.
- Issue two flag setters -> pending_cnt=2. With id_needs_flags=1 -> flag_hazard=1. Retire both -> pending_cnt=0, flag_hazard=0. Simultaneous inc and dec -> count unchanged.
- pending_cnt=2 then flush=1 (with stall=1 and inc requested) -> pending_cnt=0. Three setters issued, then a fourth -> pending_cnt stays 3, cnt_err=1. A dec at 0 also sets cnt_err=1, which holds until reset.
- With STATUS_BYPASS_EN: commit alu_flags=4'b1001 -> status_out=4'b1001 in the same cycle. With pending_cnt=1, retire=1 and id_needs_flags=1 -> flag_hazard=0.
